// File: rtl/move_scheduler.sv
// -----------------------------------------------------------------------------
// move_scheduler
//
// Sequences one game turn. Move requests from the debounced buttons or the
// debug port are queued (one entry), then the move engine is started, and
// once it finishes the tile spawner is started (unless the move changed
// nothing and SPAWN_ON_NOCHANGE is 0). Debug grid writes are buffered (one
// entry) and only issued to the grid register file while the scheduler is
// idle, so a write can never land in the middle of a move.
//
// Parameters
//   TIMEOUT_CYCLES    cycles to wait for move_done / spawn_done before the
//                     turn is abandoned (1..255)
//   SPAWN_ON_NOCHANGE 1: spawn even when the move changed nothing
//
// Ports
//   clk, rst          clock (rising edge) and asynchronous active-high reset
//   btn_move[3:0]     one-hot move pulses, bit0=up 1=right 2=down 3=left
//   force_move[3:0]   debug move pulses, same encoding, wins over btn_move
//   dbg_wr_valid      debug grid write strobe
//   dbg_wr_addr[3:0]  debug write cell index
//   dbg_wr_data[3:0]  debug write tile exponent
//   move_start        pulse: move engine begins move_dir
//   move_dir[1:0]     direction, held from move_start until the next start
//   move_done         move engine finished (pulse)
//   move_changed      grid changed by the move, valid with move_done
//   spawn_start       pulse: tile spawner begins
//   spawn_done        tile spawner finished (pulse)
//   grid_we           grid write enable (pulse)
//   grid_waddr[3:0]   grid write address
//   grid_wdata[3:0]   grid write data
//   busy              high whenever the FSM is not idle
//   dbg_overflow      sticky: a buffered debug write was overwritten
//   timeout_err       sticky: a done pulse did not arrive in time
// -----------------------------------------------------------------------------
module move_scheduler #(
    parameter int TIMEOUT_CYCLES    = 255,
    parameter int SPAWN_ON_NOCHANGE = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] btn_move,
    input  logic [3:0] force_move,
    input  logic       dbg_wr_valid,
    input  logic [3:0] dbg_wr_addr,
    input  logic [3:0] dbg_wr_data,
    output logic       move_start,
    output logic [1:0] move_dir,
    input  logic       move_done,
    input  logic       move_changed,
    output logic       spawn_start,
    input  logic       spawn_done,
    output logic       grid_we,
    output logic [3:0] grid_waddr,
    output logic [3:0] grid_wdata,
    output logic       busy,
    output logic       dbg_overflow,
    output logic       timeout_err
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_MOVE  = 2'd1,
        ST_SPAWN = 2'd2
    } state_t;

    // Last counter value before expiry: waiting cycles are counted 0..N-1.
    localparam logic [7:0] TMO_LAST  = 8'(TIMEOUT_CYCLES - 1);
    localparam logic       SPAWN_ALW = (SPAWN_ON_NOCHANGE != 0);

    state_t     state_q, state_d;
    logic [7:0] tmo_cnt_q, tmo_cnt_d;

    logic       pend_valid_q, pend_valid_d;
    logic [1:0] pend_dir_q, pend_dir_d;

    logic       wbuf_valid_q, wbuf_valid_d;
    logic [3:0] wbuf_addr_q, wbuf_addr_d;
    logic [3:0] wbuf_data_q, wbuf_data_d;

    logic       move_start_q, move_start_d;
    logic [1:0] move_dir_q, move_dir_d;
    logic       spawn_start_q, spawn_start_d;
    logic       grid_we_q, grid_we_d;
    logic [3:0] grid_waddr_q, grid_waddr_d;
    logic [3:0] grid_wdata_q, grid_wdata_d;
    logic       busy_q, busy_d;
    logic       dbg_overflow_q, dbg_overflow_d;
    logic       timeout_err_q, timeout_err_d;

    logic       req_valid_s;
    logic [3:0] req_vec_s;
    logic [1:0] req_dir_s;

    // Request decode: debug vector wins, then lowest set bit picks the direction.
    always_comb begin
        req_vec_s   = (force_move != 4'd0) ? force_move : btn_move;
        req_valid_s = (req_vec_s != 4'd0);
        if (req_vec_s[0]) begin
            req_dir_s = 2'd0;
        end else if (req_vec_s[1]) begin
            req_dir_s = 2'd1;
        end else if (req_vec_s[2]) begin
            req_dir_s = 2'd2;
        end else begin
            req_dir_s = 2'd3;
        end
    end

    // Next-state, buffer and output logic.
    always_comb begin
        state_d        = state_q;
        tmo_cnt_d      = tmo_cnt_q;
        pend_valid_d   = pend_valid_q;
        pend_dir_d     = pend_dir_q;
        wbuf_valid_d   = wbuf_valid_q;
        wbuf_addr_d    = wbuf_addr_q;
        wbuf_data_d    = wbuf_data_q;
        move_start_d   = 1'b0;
        move_dir_d     = move_dir_q;
        spawn_start_d  = 1'b0;
        grid_we_d      = 1'b0;
        grid_waddr_d   = grid_waddr_q;
        grid_wdata_d   = grid_wdata_q;
        dbg_overflow_d = dbg_overflow_q;
        timeout_err_d  = timeout_err_q;

        // Capture a debug write. In IDLE a full buffer is drained on this
        // same edge, so the new write replaces nothing that is lost.
        if (dbg_wr_valid) begin
            wbuf_valid_d = 1'b1;
            wbuf_addr_d  = dbg_wr_addr;
            wbuf_data_d  = dbg_wr_data;
            if (wbuf_valid_q && (state_q != ST_IDLE)) begin
                dbg_overflow_d = 1'b1;
            end else begin
                dbg_overflow_d = dbg_overflow_q;
            end
        end else begin
            wbuf_valid_d = wbuf_valid_q;
        end

        // Capture a move request only into an empty pending slot.
        if (req_valid_s && !pend_valid_q) begin
            pend_valid_d = 1'b1;
            pend_dir_d   = req_dir_s;
        end else begin
            pend_valid_d = pend_valid_q;
        end

        case (state_q)
            ST_IDLE: begin
                if (wbuf_valid_q || dbg_wr_valid) begin
                    // Buffered entry is older, so it goes first; a fresh
                    // write with an empty buffer bypasses it for 1-cycle latency.
                    grid_we_d = 1'b1;
                    if (wbuf_valid_q) begin
                        grid_waddr_d = wbuf_addr_q;
                        grid_wdata_d = wbuf_data_q;
                    end else begin
                        grid_waddr_d = dbg_wr_addr;
                        grid_wdata_d = dbg_wr_data;
                    end
                    wbuf_valid_d = wbuf_valid_q & dbg_wr_valid;
                end else if (pend_valid_q || req_valid_s) begin
                    move_start_d = 1'b1;
                    if (pend_valid_q) begin
                        move_dir_d = pend_dir_q;
                    end else begin
                        move_dir_d = req_dir_s;
                    end
                    // A request arriving while the slot was full is dropped.
                    pend_valid_d = 1'b0;
                    tmo_cnt_d    = 8'd0;
                    state_d      = ST_MOVE;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_MOVE: begin
                if (move_done) begin
                    if (move_changed || SPAWN_ALW) begin
                        spawn_start_d = 1'b1;
                        tmo_cnt_d     = 8'd0;
                        state_d       = ST_SPAWN;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else if (tmo_cnt_q == TMO_LAST) begin
                    timeout_err_d = 1'b1;
                    state_d       = ST_IDLE;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + 8'd1;
                end
            end
            ST_SPAWN: begin
                if (spawn_done) begin
                    state_d = ST_IDLE;
                end else if (tmo_cnt_q == TMO_LAST) begin
                    timeout_err_d = 1'b1;
                    state_d       = ST_IDLE;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + 8'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    // State, buffers and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= ST_IDLE;
            tmo_cnt_q      <= 8'd0;
            pend_valid_q   <= 1'b0;
            pend_dir_q     <= 2'd0;
            wbuf_valid_q   <= 1'b0;
            wbuf_addr_q    <= 4'd0;
            wbuf_data_q    <= 4'd0;
            move_start_q   <= 1'b0;
            move_dir_q     <= 2'd0;
            spawn_start_q  <= 1'b0;
            grid_we_q      <= 1'b0;
            grid_waddr_q   <= 4'd0;
            grid_wdata_q   <= 4'd0;
            busy_q         <= 1'b0;
            dbg_overflow_q <= 1'b0;
            timeout_err_q  <= 1'b0;
        end else begin
            state_q        <= state_d;
            tmo_cnt_q      <= tmo_cnt_d;
            pend_valid_q   <= pend_valid_d;
            pend_dir_q     <= pend_dir_d;
            wbuf_valid_q   <= wbuf_valid_d;
            wbuf_addr_q    <= wbuf_addr_d;
            wbuf_data_q    <= wbuf_data_d;
            move_start_q   <= move_start_d;
            move_dir_q     <= move_dir_d;
            spawn_start_q  <= spawn_start_d;
            grid_we_q      <= grid_we_d;
            grid_waddr_q   <= grid_waddr_d;
            grid_wdata_q   <= grid_wdata_d;
            busy_q         <= busy_d;
            dbg_overflow_q <= dbg_overflow_d;
            timeout_err_q  <= timeout_err_d;
        end
    end

    assign move_start   = move_start_q;
    assign move_dir     = move_dir_q;
    assign spawn_start  = spawn_start_q;
    assign grid_we      = grid_we_q;
    assign grid_waddr   = grid_waddr_q;
    assign grid_wdata   = grid_wdata_q;
    assign busy         = busy_q;
    assign dbg_overflow = dbg_overflow_q;
    assign timeout_err  = timeout_err_q;

endmodule

// File: tb/tb_move_scheduler.sv
// -----------------------------------------------------------------------------
// tb_move_scheduler
//
// Directed bench for move_scheduler (TIMEOUT_CYCLES=4, SPAWN_ON_NOCHANGE=0).
// Stimulus pushes the expected output events (move start / spawn start /
// grid write) into a queue; a monitor pops and compares on every event.
// Cycle-exact checks (latency, busy, sticky flags) are done inline.
// -----------------------------------------------------------------------------
module tb_move_scheduler;

    localparam logic [1:0] EV_MOVE  = 2'd0;
    localparam logic [1:0] EV_SPAWN = 2'd1;
    localparam logic [1:0] EV_WRITE = 2'd2;

    typedef struct packed {
        logic [1:0] kind;
        logic [3:0] a;
        logic [3:0] b;
    } ev_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] btn_move = 4'd0;
    logic [3:0] force_move = 4'd0;
    logic       dbg_wr_valid = 1'b0;
    logic [3:0] dbg_wr_addr = 4'd0;
    logic [3:0] dbg_wr_data = 4'd0;
    logic       move_start;
    logic [1:0] move_dir;
    logic       move_done = 1'b0;
    logic       move_changed = 1'b0;
    logic       spawn_start;
    logic       spawn_done = 1'b0;
    logic       grid_we;
    logic [3:0] grid_waddr;
    logic [3:0] grid_wdata;
    logic       busy;
    logic       dbg_overflow;
    logic       timeout_err;

    int  checks = 0;
    int  errors = 0;
    ev_t exp_q[$];

    move_scheduler #(.TIMEOUT_CYCLES(4), .SPAWN_ON_NOCHANGE(0)) dut (
        .clk(clk), .rst(rst),
        .btn_move(btn_move), .force_move(force_move),
        .dbg_wr_valid(dbg_wr_valid), .dbg_wr_addr(dbg_wr_addr), .dbg_wr_data(dbg_wr_data),
        .move_start(move_start), .move_dir(move_dir),
        .move_done(move_done), .move_changed(move_changed),
        .spawn_start(spawn_start), .spawn_done(spawn_done),
        .grid_we(grid_we), .grid_waddr(grid_waddr), .grid_wdata(grid_wdata),
        .busy(busy), .dbg_overflow(dbg_overflow), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic expect_ev(input logic [1:0] kind, input logic [3:0] a, input logic [3:0] b);
        ev_t e;
        e.kind = kind;
        e.a    = a;
        e.b    = b;
        exp_q.push_back(e);
    endtask

    // One clock: inputs set before the call are sampled at the posedge,
    // outputs are then examined at the following negedge.
    task automatic cyc();
        @(negedge clk);
        btn_move     = 4'd0;
        force_move   = 4'd0;
        dbg_wr_valid = 1'b0;
        move_done    = 1'b0;
        move_changed = 1'b0;
        spawn_done   = 1'b0;
    endtask

    task automatic wait_idle(input string name, input int max_cyc);
        int n;
        n = 0;
        while (busy && n < max_cyc) begin
            cyc();
            n++;
        end
        check(name, {31'd0, busy}, 32'd0);
    endtask

    // Scoreboard monitor: every output event must match the queue head.
    always @(negedge clk) begin
        if (!rst && (move_start || spawn_start || grid_we)) begin
            if (exp_q.size() == 0) begin
                check("unexpected_event", {29'd0, move_start, spawn_start, grid_we}, 32'd0);
            end else begin
                ev_t e;
                e = exp_q.pop_front();
                if (move_start) begin
                    check("sb_move_kind", {30'd0, EV_MOVE}, {30'd0, e.kind});
                    check("sb_move_dir", {30'd0, move_dir}, {28'd0, e.a});
                end else if (spawn_start) begin
                    check("sb_spawn_kind", {30'd0, EV_SPAWN}, {30'd0, e.kind});
                end else begin
                    check("sb_write_kind", {30'd0, EV_WRITE}, {30'd0, e.kind});
                    check("sb_write_addr", {28'd0, grid_waddr}, {28'd0, e.a});
                    check("sb_write_data", {28'd0, grid_wdata}, {28'd0, e.b});
                    check("sb_write_not_busy", {31'd0, busy}, 32'd0);
                end
            end
        end
    end

    initial begin
        // Reset state
        cyc();
        cyc();
        check("rst_outputs", {22'd0, move_start, move_dir, spawn_start, grid_we,
                              busy, dbg_overflow, timeout_err},
              32'd0);
        rst = 1'b0;
        cyc();

        // 1: button right -> move_start dir 1, then spawn, then idle
        expect_ev(EV_MOVE, 4'd1, 4'd0);
        btn_move = 4'b0010;
        cyc();
        check("t1_move_start", {31'd0, move_start}, 32'd1);
        check("t1_move_dir", {30'd0, move_dir}, 32'd1);
        check("t1_busy", {31'd0, busy}, 32'd1);
        expect_ev(EV_SPAWN, 4'd0, 4'd0);
        move_done = 1'b1;
        move_changed = 1'b1;
        cyc();
        check("t1_spawn_start", {31'd0, spawn_start}, 32'd1);
        check("t1_dir_held", {30'd0, move_dir}, 32'd1);
        spawn_done = 1'b1;
        cyc();
        check("t1_idle", {31'd0, busy}, 32'd0);

        // 2 + 5: force wins (left), btn dropped; no-change move skips spawn
        expect_ev(EV_MOVE, 4'd3, 4'd0);
        btn_move   = 4'b0001;
        force_move = 4'b1000;
        cyc();
        check("t2_move_dir", {30'd0, move_dir}, 32'd3);
        move_done = 1'b1;
        cyc();
        check("t5_idle_next", {31'd0, busy}, 32'd0);
        check("t5_no_spawn", {31'd0, spawn_start}, 32'd0);
        cyc();
        check("t2_btn_dropped", {31'd0, move_start}, 32'd0);

        // 3: write and pending move during MOVE; write goes first in IDLE
        expect_ev(EV_MOVE, 4'd2, 4'd0);
        btn_move = 4'b0100;
        cyc();
        expect_ev(EV_WRITE, 4'd5, 4'd9);
        dbg_wr_valid = 1'b1;
        dbg_wr_addr  = 4'd5;
        dbg_wr_data  = 4'd9;
        cyc();
        check("t3_no_we_busy", {31'd0, grid_we}, 32'd0);
        expect_ev(EV_MOVE, 4'd0, 4'd0);
        btn_move = 4'b0001;
        cyc();
        move_done = 1'b1;
        cyc();
        check("t3_idle", {31'd0, busy}, 32'd0);
        cyc();
        check("t3_grid_we", {31'd0, grid_we}, 32'd1);
        cyc();
        check("t3_pending_start", {31'd0, move_start}, 32'd1);
        move_done = 1'b1;
        cyc();
        wait_idle("t3_wait_idle", 8);

        // 4: two writes during MOVE -> only the last one, overflow set
        expect_ev(EV_MOVE, 4'd3, 4'd0);
        btn_move = 4'b1000;
        cyc();
        dbg_wr_valid = 1'b1;
        dbg_wr_addr  = 4'd3;
        dbg_wr_data  = 4'd1;
        cyc();
        check("t4_no_overflow_yet", {31'd0, dbg_overflow}, 32'd0);
        expect_ev(EV_WRITE, 4'd7, 4'd2);
        dbg_wr_valid = 1'b1;
        dbg_wr_addr  = 4'd7;
        dbg_wr_data  = 4'd2;
        cyc();
        check("t4_overflow", {31'd0, dbg_overflow}, 32'd1);
        move_done = 1'b1;
        cyc();
        cyc();
        check("t4_grid_we", {31'd0, grid_we}, 32'd1);
        cyc();
        cyc();
        check("t4_single_write", {31'd0, grid_we}, 32'd0);

        // 6: no move_done -> timeout after 4 waiting cycles
        expect_ev(EV_MOVE, 4'd1, 4'd0);
        btn_move = 4'b0010;
        cyc();
        cyc();
        cyc();
        cyc();
        check("t6_busy_cycle4", {31'd0, busy}, 32'd1);
        check("t6_no_err_yet", {31'd0, timeout_err}, 32'd0);
        cyc();
        check("t6_idle_after_timeout", {31'd0, busy}, 32'd0);
        check("t6_timeout_err", {31'd0, timeout_err}, 32'd1);

        // 6: reset mid-MOVE clears all outputs immediately
        expect_ev(EV_MOVE, 4'd0, 4'd0);
        btn_move = 4'b0001;
        cyc();
        cyc();
        rst = 1'b1;
        #1;
        check("t6_rst_outputs", {22'd0, move_start, move_dir, spawn_start, grid_we,
                                 busy, dbg_overflow, timeout_err},
              32'd0);
        cyc();
        rst = 1'b0;
        cyc();
        cyc();
        check("t6_no_restart", {31'd0, busy}, 32'd0);

        // Boundary: done on the expiry cycle counts as done
        expect_ev(EV_MOVE, 4'd2, 4'd0);
        btn_move = 4'b0100;
        cyc();
        cyc();
        cyc();
        cyc();
        expect_ev(EV_SPAWN, 4'd0, 4'd0);
        move_done = 1'b1;
        move_changed = 1'b1;
        cyc();
        check("tb_done_at_expiry_spawn", {31'd0, spawn_start}, 32'd1);
        check("tb_done_at_expiry_noerr", {31'd0, timeout_err}, 32'd0);
        spawn_done = 1'b1;
        cyc();
        check("tb_spawn_idle", {31'd0, busy}, 32'd0);

        cyc();
        check("queue_empty", exp_q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
